// File: rtl/pattern_scan_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pattern_scan_pkg
// Purpose  : Shared types and width helpers for the pattern scan controller.
// Revision : 1.0  initial release
// ============================================================================
package pattern_scan_pkg;

  // Controller phases: wait for a word, shift it bit by bit, present result.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    REPORT = 2'd2
  } state_t;

  // Width needed to hold a per-word match count of 0..word_w.
  function automatic int cnt_width(input int word_w);
    return $clog2(word_w + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pattern_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : pattern_scan_ctrl_if
// Purpose  : Word-in / result-out handshake bundle for pattern_scan_ctrl.
//            master = producer/consumer side, slave = controller side.
// Revision : 1.0  initial release
// ============================================================================
interface pattern_scan_ctrl_if
  import pattern_scan_pkg::*;
#(
  parameter int WORD_W = 8,
  parameter int PAT_W  = 3,
  parameter int TOT_W  = 16
) ();

  localparam int CNT_W = cnt_width(WORD_W);
  localparam int POS_W = $clog2(WORD_W);

  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] in_data;
  logic [PAT_W-1:0]  in_pattern;
  logic              in_clear;
  logic              out_valid;
  logic              out_ready;
  logic [CNT_W-1:0]  out_count;
  logic [POS_W-1:0]  out_first_pos;
  logic [TOT_W-1:0]  total_count;

  modport master (
    output in_valid, in_data, in_pattern, in_clear, out_ready,
    input  in_ready, out_valid, out_count, out_first_pos, total_count
  );

  modport slave (
    input  in_valid, in_data, in_pattern, in_clear, out_ready,
    output in_ready, out_valid, out_count, out_first_pos, total_count
  );

endinterface
`default_nettype wire

// File: rtl/pattern_scan_ctrl_matcher.sv
`default_nettype none
// ============================================================================
// Module   : pattern_shift_matcher
// Purpose  : Bit-serial overlapping matcher. Keeps the last PAT_W bits and
//            a saturating fill count; pulses match in the cycle the
//            completing bit is shifted in.
// Revision : 1.0  initial release
// ============================================================================
module pattern_shift_matcher #(
  parameter int PAT_W = 3
) (
  input  wire logic             clk,
  input  wire logic             reset,
  input  wire logic             flush,
  input  wire logic             bit_valid,
  input  wire logic             bit_in,
  input  wire logic [PAT_W-1:0] pattern,
  output logic                  match
);

  localparam int c_FILL_W = $clog2(PAT_W + 1);
  localparam logic [c_FILL_W-1:0] c_FILL_MAX = c_FILL_W'(PAT_W);

  logic [PAT_W-1:0]    hist_q, hist_d, hist_next;
  logic [c_FILL_W-1:0] fill_q, fill_d, fill_next;

  // Oldest bit sits at the MSB; a single-bit history is just the new bit.
  generate
    if (PAT_W == 1) begin : g_single
      assign hist_next = bit_in;
    end else begin : g_multi
      assign hist_next = {hist_q[PAT_W-2:0], bit_in};
    end
  endgenerate

  assign fill_next = (fill_q == c_FILL_MAX) ? fill_q : fill_q + c_FILL_W'(1);
  assign match     = bit_valid && (hist_next == pattern) && (fill_next == c_FILL_MAX);

  // Next history: flush wins, otherwise shift on each valid bit.
  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    if (flush) begin
      hist_d = '0;
      fill_d = '0;
    end else if (bit_valid) begin
      hist_d = hist_next;
      fill_d = fill_next;
    end
  end

  // History and fill registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pattern_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pattern_scan_ctrl
// Purpose  : Accepts a word + pattern, scans the word MSB-first through an
//            overlapping matcher, reports the per-word match count and keeps
//            a saturating running total.
//            Optional macro SCAN_FIRST_POS_EN: report the bit index of the
//            first match in the word (otherwise out_first_pos is 0).
// Revision : 1.0  initial release
// ============================================================================
module pattern_scan_ctrl
  import pattern_scan_pkg::*;
#(
  parameter int WORD_W = 8,
  parameter int PAT_W  = 3,
  parameter int TOT_W  = 16
) (
  input  wire logic           clk,
  input  wire logic           reset,
  pattern_scan_ctrl_if.slave  bus
);

  localparam int c_CNT_W = cnt_width(WORD_W);
  localparam int c_IDX_W = $clog2(WORD_W);
  localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(WORD_W - 1);

  state_t              state_q, state_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic [PAT_W-1:0]    pat_q, pat_d;
  logic [c_IDX_W-1:0]  idx_q, idx_d;
  logic [c_CNT_W-1:0]  cnt_q, cnt_d;
  logic [TOT_W-1:0]    tot_q, tot_d;
  logic                flush, bit_valid, match;

  assign bit_valid = (state_q == SHIFT);

  pattern_shift_matcher #(
    .PAT_W (PAT_W)
  ) u_matcher (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .bit_valid (bit_valid),
    .bit_in    (word_q[idx_q]),
    .pattern   (pat_q),
    .match     (match)
  );

  // Next-state, datapath updates and handshake decisions.
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    pat_d   = pat_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    tot_d   = tot_q;
    flush   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          word_d  = bus.in_data;
          pat_d   = bus.in_pattern;
          idx_d   = c_LAST_IDX;
          cnt_d   = '0;
          flush   = bus.in_clear;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (match) begin
          cnt_d = cnt_q + c_CNT_W'(1);
          if (tot_q != '1) begin
            tot_d = tot_q + TOT_W'(1);
          end
        end
        if (idx_q == '0) begin
          state_d = REPORT;
        end else begin
          idx_d = idx_q - c_IDX_W'(1);
        end
      end
      REPORT: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      word_q  <= '0;
      pat_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      tot_q   <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      pat_q   <= pat_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      tot_q   <= tot_d;
    end
  end

`ifdef SCAN_FIRST_POS_EN
  logic [c_IDX_W-1:0] pos_q, pos_d;

  // Capture the bit index of the first match of the current word.
  always_comb begin
    pos_d = pos_q;
    if (state_q == IDLE && bus.in_valid) begin
      pos_d = '0;
    end else if (match && cnt_q == '0) begin
      pos_d = idx_q;
    end
  end

  // First-match position register.
  always_ff @(posedge clk) begin
    if (reset) begin
      pos_q <= '0;
    end else begin
      pos_q <= pos_d;
    end
  end

  assign bus.out_first_pos = pos_q;
`else
  assign bus.out_first_pos = '0;
`endif

  assign bus.in_ready    = (state_q == IDLE);
  assign bus.out_valid   = (state_q == REPORT);
  assign bus.out_count   = cnt_q;
  assign bus.total_count = tot_q;

endmodule
`default_nettype wire

// File: tb/tb_pattern_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pattern_scan_ctrl
// Purpose  : Directed self-checking bench for pattern_scan_ctrl with a
//            stream-level match model and a per-cycle result comparator.
// Revision : 1.0  initial release
// ============================================================================
module tb_pattern_scan_ctrl;

  localparam int WORD_W = 8;
  localparam int PAT_W  = 3;
  localparam int TOT_W  = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  pattern_scan_ctrl_if #(.WORD_W(WORD_W), .PAT_W(PAT_W), .TOT_W(TOT_W)) bus ();
  pattern_scan_ctrl_if #(.WORD_W(8), .PAT_W(1), .TOT_W(4)) sbus ();

  pattern_scan_ctrl #(.WORD_W(WORD_W), .PAT_W(PAT_W), .TOT_W(TOT_W)) dut (
    .clk (clk), .reset (reset), .bus (bus)
  );

  pattern_scan_ctrl #(.WORD_W(8), .PAT_W(1), .TOT_W(4)) dut_sat (
    .clk (clk), .reset (reset), .bus (sbus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Model state: recent scanned bits (since last clear), running total,
  // and the queued expected result of each accepted word.
  bit stream[$];
  int m_total = 0;
  int exp_cnt[$];
  int exp_pos[$];
  int exp_tot[$];
  int last_cnt;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Scan one word against the bit stream: a match is any position where
  // the newest PAT_W bits of the stream spell the pattern.
  task automatic model_word(input logic [WORD_W-1:0] d, input logic [PAT_W-1:0] p,
                            input logic clr);
    int cnt = 0;
    int pos = 0;
    bit ok;
    if (clr) stream.delete();
    for (int i = WORD_W - 1; i >= 0; i--) begin
      stream.push_back(d[i]);
      if (stream.size() > PAT_W) void'(stream.pop_front());
      if (stream.size() == PAT_W) begin
        ok = 1'b1;
        for (int k = 0; k < PAT_W; k++)
          if (stream[k] != p[PAT_W-1-k]) ok = 1'b0;
        if (ok) begin
          if (cnt == 0) pos = i;
          cnt++;
        end
      end
    end
    m_total = (m_total + cnt > 65535) ? 65535 : m_total + cnt;
    exp_cnt.push_back(cnt);
    exp_pos.push_back(pos);
    exp_tot.push_back(m_total);
  endtask

  task automatic model_reset();
    stream.delete();
    m_total = 0;
    exp_cnt.delete();
    exp_pos.delete();
    exp_tot.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
  endtask

  // Present a word and complete the input handshake (bounded wait).
  task automatic accept(input logic [WORD_W-1:0] d, input logic [PAT_W-1:0] p,
                        input logic clr);
    int guard = 0;
    while (!bus.in_ready && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    chk("accept_ready", int'(bus.in_ready), 1);
    bus.in_valid = 1'b1; bus.in_data = d; bus.in_pattern = p; bus.in_clear = clr;
    @(posedge clk);
    model_word(d, p, clr);
    #1 bus.in_valid = 1'b0; bus.in_clear = 1'b0;
  endtask

  // out_valid must rise exactly WORD_W edges after the accept edge.
  task automatic wait_result();
    for (int k = 1; k <= WORD_W; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("latency_valid_k%0d", k), int'(bus.out_valid), (k == WORD_W) ? 1 : 0);
      chk($sformatf("busy_ready_k%0d", k), int'(bus.in_ready), 0);
    end
  endtask

  // Hold the consumer off for 'hold' cycles, then take the result.
  task automatic collect(input int hold);
    last_cnt = int'(bus.out_count);
    repeat (hold) begin
      @(negedge clk);
      chk("hold_valid", int'(bus.out_valid), 1);
      chk("hold_in_ready", int'(bus.in_ready), 0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    void'(exp_cnt.pop_front());
    void'(exp_pos.pop_front());
    void'(exp_tot.pop_front());
    #1 bus.out_ready = 1'b0; bus.in_valid = 1'b0;
    @(negedge clk);
    chk("post_valid", int'(bus.out_valid), 0);
    chk("post_in_ready", int'(bus.in_ready), 1);
  endtask

  // Compare every cycle a result is presented against the model.
  always @(negedge clk) begin
    if (!reset && bus.out_valid) begin
      if (exp_cnt.size() == 0) begin
        chk("unexpected_result", 1, 0);
      end else begin
        chk("out_count", int'(bus.out_count), exp_cnt[0]);
`ifdef SCAN_FIRST_POS_EN
        chk("out_first_pos", int'(bus.out_first_pos), exp_pos[0]);
`else
        chk("out_first_pos", int'(bus.out_first_pos), 0);
`endif
        chk("total_count", int'(bus.total_count), exp_tot[0]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int s_total;
    int guard;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_pattern = '0;
    bus.in_clear = 1'b0; bus.out_ready = 1'b0;
    sbus.in_valid = 1'b0; sbus.in_data = '0; sbus.in_pattern = '0;
    sbus.in_clear = 1'b0; sbus.out_ready = 1'b0;

    // Reset state.
    do_reset();
    @(negedge clk);
    chk("rst_in_ready", int'(bus.in_ready), 1);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out_count", int'(bus.out_count), 0);
    chk("rst_first_pos", int'(bus.out_first_pos), 0);
    chk("rst_total", int'(bus.total_count), 0);

    // Basic overlapping scan: 1010_1010 / 101 -> 3 matches, first at 5.
    accept(8'b1010_1010, 3'b101, 1'b1);
    wait_result();
    chk("lit_basic_count", int'(bus.out_count), 3);
    chk("lit_basic_total", int'(bus.total_count), 3);
`ifdef SCAN_FIRST_POS_EN
    chk("lit_basic_pos", int'(bus.out_first_pos), 5);
`endif
    collect(0);

    // Pattern spanning a word boundary.
    do_reset();
    accept(8'b0000_0010, 3'b101, 1'b0);
    wait_result();
    chk("lit_cross_a", int'(bus.out_count), 0);
    collect(0);
    accept(8'b1000_0000, 3'b101, 1'b0);
    wait_result();
    chk("lit_cross_b", int'(bus.out_count), 1);
    chk("lit_cross_total", int'(bus.total_count), 1);
    collect(0);

    // Same boundary with history cleared on the second word.
    accept(8'b0000_0010, 3'b101, 1'b0);
    wait_result();
    collect(0);
    accept(8'b1000_0000, 3'b101, 1'b1);
    wait_result();
    chk("lit_clear_b", int'(bus.out_count), 0);
    collect(0);

    // Other patterns exercise different overlap shapes.
    accept(8'b1111_1111, 3'b111, 1'b1);
    wait_result();
    collect(0);
    accept(8'b0110_1101, 3'b011, 1'b0);
    wait_result();
    collect(0);

    // Backpressure with a competing input offer that must be ignored.
    accept(8'b1010_1010, 3'b101, 1'b0);
    wait_result();
    bus.in_valid = 1'b1; bus.in_data = 8'hFF; bus.in_pattern = 3'b111;
    collect(5);
    chk("bp_count_stable", last_cnt, exp_cnt.size() == 0 ? 3 : -1);

    // Reset in the 4th shift cycle after three bits 1,0,1 were scanned.
    accept(8'b1010_0000, 3'b101, 1'b0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
    @(negedge clk);
    chk("midrst_in_ready", int'(bus.in_ready), 1);
    chk("midrst_out_valid", int'(bus.out_valid), 0);
    chk("midrst_total", int'(bus.total_count), 0);
    accept(8'b0100_0000, 3'b101, 1'b0);
    wait_result();
    chk("lit_midrst_count", int'(bus.out_count), 0);
    collect(0);

    // Saturation on the PAT_W=1 / TOT_W=4 instance.
    s_total = 0;
    for (int w = 0; w < 3; w++) begin
      sbus.in_valid = 1'b1; sbus.in_data = 8'hFF; sbus.in_pattern = 1'b1;
      sbus.in_clear = 1'b0;
      @(posedge clk);
      #1 sbus.in_valid = 1'b0;
      s_total = (s_total + 8 > 15) ? 15 : s_total + 8;
      guard = 0;
      while (!sbus.out_valid && guard < 20) begin
        @(negedge clk); guard++;
      end
      chk($sformatf("sat_valid_w%0d", w), int'(sbus.out_valid), 1);
      chk($sformatf("sat_count_w%0d", w), int'(sbus.out_count), 8);
      chk($sformatf("sat_total_w%0d", w), int'(sbus.total_count), s_total);
      sbus.out_ready = 1'b1;
      @(posedge clk);
      #1 sbus.out_ready = 1'b0;
    end
    chk("lit_sat_total", int'(sbus.total_count), 15);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
